// File: rtl/fakeram_64x22_arbiter_if.sv
// -----------------------------------------------------------------------------
// fakeram_64x22_arbiter_if
//
// Bundles every non-clock signal of the two-requester fakeram arbiter:
//   requester A / B : valid, ready, we, addr, wdata request channel plus the
//                     rsp_valid / rsp_data read-response channel
//   RAM side        : ram_ce, ram_we, ram_addr, ram_wd towards the macro and
//                     ram_rd coming back from it
//   status          : conflict_cnt, saturating count of contended cycles
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (both requesters and the RAM macro)
// -----------------------------------------------------------------------------
interface fakeram_64x22_arbiter_if #(
   parameter int BITS       = 22,
   parameter int ADDR_WIDTH = 6,
   parameter int CNT_WIDTH  = 16
);

   logic                  a_valid;
   logic                  a_ready;
   logic                  a_we;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [BITS-1:0]       a_wdata;
   logic                  a_rsp_valid;
   logic [BITS-1:0]       a_rsp_data;

   logic                  b_valid;
   logic                  b_ready;
   logic                  b_we;
   logic [ADDR_WIDTH-1:0] b_addr;
   logic [BITS-1:0]       b_wdata;
   logic                  b_rsp_valid;
   logic [BITS-1:0]       b_rsp_data;

   logic                  ram_ce;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [BITS-1:0]       ram_wd;
   logic [BITS-1:0]       ram_rd;

   logic [CNT_WIDTH-1:0]  conflict_cnt;

   modport slave (
      input  a_valid, a_we, a_addr, a_wdata,
      output a_ready, a_rsp_valid, a_rsp_data,
      input  b_valid, b_we, b_addr, b_wdata,
      output b_ready, b_rsp_valid, b_rsp_data,
      output ram_ce, ram_we, ram_addr, ram_wd,
      input  ram_rd,
      output conflict_cnt
   );

   modport master (
      output a_valid, a_we, a_addr, a_wdata,
      input  a_ready, a_rsp_valid, a_rsp_data,
      output b_valid, b_we, b_addr, b_wdata,
      input  b_ready, b_rsp_valid, b_rsp_data,
      input  ram_ce, ram_we, ram_addr, ram_wd,
      output ram_rd,
      input  conflict_cnt
   );

endinterface

// File: rtl/fakeram_64x22_arbiter.sv
// -----------------------------------------------------------------------------
// fakeram_64x22_arbiter
//
// Shares one single-port fakeram_64x22 macro between two requesters (A, B)
// with round-robin arbitration and one RAM access per cycle.
//
// Ports:
//   clk     - single clock, everything updates on posedge
//   rst_n   - synchronous reset, active-low
//   bus_io  - fakeram_64x22_arbiter_if.slave: both request/response channels,
//             the registered RAM-side signals and the conflict counter
//
// Timing of an accept in cycle N:
//   N   : x_ready high (combinational from valids and the priority pointer)
//   N+1 : ram_ce/we/addr/wd driven from registers, RAM samples at end of N+1
//   N+2 : ram_rd valid, forwarded combinationally as x_rsp_data with
//         x_rsp_valid for reads only, to the owning requester only
//
// Idle cycles drive all-zero RAM controls so the macro never sees X on
// we/addr while ce is high.
// -----------------------------------------------------------------------------
module fakeram_64x22_arbiter #(
   parameter int BITS       = 22,
   parameter int WORD_DEPTH = 64,
   parameter int ADDR_WIDTH = 6,
   parameter int CNT_WIDTH  = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   fakeram_64x22_arbiter_if.slave bus_io
);

   // The address bus must cover exactly the RAM's word range.
   if (WORD_DEPTH != (1 << ADDR_WIDTH)) begin : g_cfg_check
      $error("fakeram_64x22_arbiter: WORD_DEPTH must equal 2**ADDR_WIDTH");
   end

   // Priority pointer: names the requester that wins the next contended cycle.
   typedef enum logic {
      PTR_A = 1'b0,
      PTR_B = 1'b1
   } ptr_e;

   ptr_e                  ptr_q;
   ptr_e                  ptr_d;

   logic                  a_grant;
   logic                  b_grant;
   logic                  accept;

   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [BITS-1:0]       sel_wdata;

   logic                  ram_ce_q;
   logic                  ram_ce_d;
   logic                  ram_we_q;
   logic                  ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q;
   logic [ADDR_WIDTH-1:0] ram_addr_d;
   logic [BITS-1:0]       ram_wd_q;
   logic [BITS-1:0]       ram_wd_d;

   // Read tracking: vld = accepted read, own = 0 for A, 1 for B.
   logic                  rd_vld_p1_q;
   logic                  rd_vld_p1_d;
   logic                  rd_own_p1_q;
   logic                  rd_own_p1_d;
   logic                  rd_vld_p2_q;
   logic                  rd_own_p2_q;

   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [CNT_WIDTH-1:0]  cnt_d;

   logic                  a_rsp_vld;
   logic                  b_rsp_vld;

   // Saturating increment: sticks at all-ones instead of wrapping to zero.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (&v) begin
         return v;
      end
      return v + CNT_WIDTH'(1);
   endfunction

   // ---------------------------------------------------------------------------
   // Arbiter FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= PTR_A;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Arbiter FSM: next state. After an accept, priority passes to the other side.
   always_comb begin
      ptr_d = ptr_q;
      if (a_grant) begin
         ptr_d = PTR_B;
      end else if (b_grant) begin
         ptr_d = PTR_A;
      end
   end

   // Arbiter FSM: outputs. A lone requester always wins; the pointer only
   // matters when both are valid, so at most one grant is ever high.
   always_comb begin
      a_grant = bus_io.a_valid & (~bus_io.b_valid | (ptr_q == PTR_A));
      b_grant = bus_io.b_valid & (~bus_io.a_valid | (ptr_q == PTR_B));
   end

   // Request mux and next RAM-side values. Unaccepted cycles force zeros so
   // nothing undriven on the requester side can leak onto the macro pins.
   always_comb begin
      accept    = a_grant | b_grant;
      sel_we    = bus_io.a_we;
      sel_addr  = bus_io.a_addr;
      sel_wdata = bus_io.a_wdata;
      if (b_grant) begin
         sel_we    = bus_io.b_we;
         sel_addr  = bus_io.b_addr;
         sel_wdata = bus_io.b_wdata;
      end

      ram_ce_d    = accept;
      ram_we_d    = 1'b0;
      ram_addr_d  = '0;
      ram_wd_d    = '0;
      rd_vld_p1_d = 1'b0;
      rd_own_p1_d = 1'b0;
      if (accept) begin
         ram_we_d    = sel_we;
         ram_addr_d  = sel_addr;
         ram_wd_d    = sel_we ? sel_wdata : '0;
         rd_vld_p1_d = ~sel_we;
         rd_own_p1_d = b_grant;
      end

      cnt_d = cnt_q;
      if (bus_io.a_valid & bus_io.b_valid) begin
         cnt_d = sat_inc(cnt_q);
      end
   end

   // ---------------------------------------------------------------------------
   // Stage p1: RAM command registers, driven to the macro during cycle N+1
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ram_ce_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wd_q    <= '0;
         rd_vld_p1_q <= 1'b0;
         rd_own_p1_q <= 1'b0;
      end else begin
         ram_ce_q    <= ram_ce_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wd_q    <= ram_wd_d;
         rd_vld_p1_q <= rd_vld_p1_d;
         rd_own_p1_q <= rd_own_p1_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage p2: read tag aligned with ram_rd during cycle N+2
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_vld_p2_q <= 1'b0;
         rd_own_p2_q <= 1'b0;
      end else begin
         rd_vld_p2_q <= rd_vld_p1_q;
         rd_own_p2_q <= rd_own_p1_q;
      end
   end

   // Conflict counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Response steering: ram_rd is passed through unregistered and zeroed
   // whenever the requester has no valid response.
   always_comb begin
      a_rsp_vld = rd_vld_p2_q & ~rd_own_p2_q;
      b_rsp_vld = rd_vld_p2_q &  rd_own_p2_q;
   end

   assign bus_io.a_ready      = a_grant;
   assign bus_io.b_ready      = b_grant;
   assign bus_io.a_rsp_valid  = a_rsp_vld;
   assign bus_io.b_rsp_valid  = b_rsp_vld;
   assign bus_io.a_rsp_data   = a_rsp_vld ? bus_io.ram_rd : '0;
   assign bus_io.b_rsp_data   = b_rsp_vld ? bus_io.ram_rd : '0;
   assign bus_io.ram_ce       = ram_ce_q;
   assign bus_io.ram_we       = ram_we_q;
   assign bus_io.ram_addr     = ram_addr_q;
   assign bus_io.ram_wd       = ram_wd_q;
   assign bus_io.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_fakeram_64x22_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fakeram_64x22_arbiter
//
// Drives both requesters through directed phases, models the fakeram macro
// (OR-on-write, registered read) and checks every cycle against a reference
// model of the arbiter; read responses are predicted into a queue when the
// request is accepted and popped when due.
// -----------------------------------------------------------------------------
module tb_fakeram_64x22_arbiter;

   localparam int BITS       = 22;
   localparam int WORD_DEPTH = 64;
   localparam int ADDR_WIDTH = 6;
   localparam int CNT_WIDTH  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fakeram_64x22_arbiter_if #(
      .BITS(BITS), .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)
   ) bus ();

   fakeram_64x22_arbiter #(
      .BITS(BITS), .WORD_DEPTH(WORD_DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus_io(bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // RAM macro model: OR-on-write, registered read.
   logic [BITS-1:0] ram_mem [WORD_DEPTH] = '{default: '0};

   always @(posedge clk) begin
      if (bus.ram_ce === 1'b1) begin
         if (bus.ram_we === 1'b1) begin
            ram_mem[bus.ram_addr] <= ram_mem[bus.ram_addr] | bus.ram_wd;
         end else begin
            bus.ram_rd <= ram_mem[bus.ram_addr];
         end
      end
   end

   // Reference model and scoreboard
   typedef struct {
      int              due;
      logic            owner;
      logic [BITS-1:0] data;
   } rsp_t;

   rsp_t                  sb[$];
   logic [BITS-1:0]       ref_mem [WORD_DEPTH] = '{default: '0};
   int                    cyc     = 0;
   bit                    armed   = 1'b0;
   logic                  exp_ptr = 1'b0;
   logic                  exp_ce  = 1'b0;
   logic                  exp_we  = 1'b0;
   logic [ADDR_WIDTH-1:0] exp_addr = '0;
   logic [BITS-1:0]       exp_wd  = '0;
   logic [CNT_WIDTH-1:0]  exp_cnt = '0;
   int                    a_seen  = 0;
   int                    b_seen  = 0;

   always @(negedge clk) begin : monitor
      logic                  ea, eb, eav, ebv, s_we;
      logic [ADDR_WIDTH-1:0] s_addr;
      logic [BITS-1:0]       s_wd, ed;
      rsp_t                  e;
      ea = 1'b0;
      eb = 1'b0;
      if (armed) begin
         ea = bus.a_valid & (~bus.b_valid | ~exp_ptr);
         eb = bus.b_valid & (~bus.a_valid |  exp_ptr);
         check("a_ready",      32'(bus.a_ready),      32'(ea));
         check("b_ready",      32'(bus.b_ready),      32'(eb));
         check("ram_ce",       32'(bus.ram_ce),       32'(exp_ce));
         check("ram_we",       32'(bus.ram_we),       32'(exp_we));
         check("ram_addr",     32'(bus.ram_addr),     32'(exp_addr));
         check("ram_wd",       32'(bus.ram_wd),       32'(exp_wd));
         check("conflict_cnt", 32'(bus.conflict_cnt), 32'(exp_cnt));
         eav = 1'b0;
         ebv = 1'b0;
         ed  = '0;
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.owner) ebv = 1'b1;
            else         eav = 1'b1;
            ed = e.data;
         end
         check("a_rsp_valid", 32'(bus.a_rsp_valid), 32'(eav));
         check("b_rsp_valid", 32'(bus.b_rsp_valid), 32'(ebv));
         check("a_rsp_data",  32'(bus.a_rsp_data),  32'(eav ? ed : '0));
         check("b_rsp_data",  32'(bus.b_rsp_data),  32'(ebv ? ed : '0));
         if (bus.ram_ce === 1'b1) begin
            check("ram_ctl_known", 32'($isunknown({bus.ram_we, bus.ram_addr})), 32'(0));
         end
         if (bus.a_rsp_valid === 1'b1) a_seen++;
         if (bus.b_rsp_valid === 1'b1) b_seen++;
      end
      if (rst_n === 1'b0) begin
         armed    = 1'b1;
         sb.delete();
         exp_ptr  = 1'b0;
         exp_ce   = 1'b0;
         exp_we   = 1'b0;
         exp_addr = '0;
         exp_wd   = '0;
         exp_cnt  = '0;
      end else if (armed) begin
         if ((bus.a_valid & bus.b_valid) && (exp_cnt != '1)) exp_cnt = exp_cnt + CNT_WIDTH'(1);
         if (eb) begin
            s_we = bus.b_we; s_addr = bus.b_addr; s_wd = bus.b_wdata;
         end else begin
            s_we = bus.a_we; s_addr = bus.a_addr; s_wd = bus.a_wdata;
         end
         exp_ce   = ea | eb;
         exp_we   = (ea | eb) & s_we;
         exp_addr = (ea | eb) ? s_addr : '0;
         exp_wd   = ((ea | eb) & s_we) ? s_wd : '0;
         if (ea | eb) begin
            if (s_we) begin
               ref_mem[s_addr] = ref_mem[s_addr] | s_wd;
            end else begin
               e.due   = cyc + 2;
               e.owner = eb;
               e.data  = ref_mem[s_addr];
               sb.push_back(e);
            end
            exp_ptr = ea;
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic v, input logic we, input logic [ADDR_WIDTH-1:0] addr,
                        input logic [BITS-1:0] wd);
      bus.a_valid = v; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
   endtask

   task automatic set_b(input logic v, input logic we, input logic [ADDR_WIDTH-1:0] addr,
                        input logic [BITS-1:0] wd);
      bus.b_valid = v; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
   endtask

   initial begin : stimulus
      int a0, b0;
      set_a(1'b0, 1'b0, '0, '0);
      set_b(1'b0, 1'b0, '0, '0);

      // Reset then idle
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      check("idle_cnt", 32'(bus.conflict_cnt), 32'(0));
      check("idle_ce",  32'(bus.ram_ce),       32'(0));
      check("idle_rsp", 32'({bus.a_rsp_valid, bus.b_rsp_valid}), 32'(0));

      // A alone: write then read the same address back-to-back
      a0 = a_seen;
      b0 = b_seen;
      set_a(1'b1, 1'b1, 6'd5, 22'h0ABCDE);
      tick();
      check("a_wr_ctl", 32'({bus.ram_ce, bus.ram_we, bus.ram_addr}), 32'({1'b1, 1'b1, 6'd5}));
      set_a(1'b1, 1'b0, 6'd5, '0);
      tick();
      set_a(1'b0, 1'b0, '0, '0);
      check("a_rd_ctl", 32'({bus.ram_ce, bus.ram_we, bus.ram_addr}), 32'({1'b1, 1'b0, 6'd5}));
      check("a_rd_early", 32'(bus.a_rsp_valid), 32'(0));
      tick();
      check("a_rsp_valid_n2", 32'(bus.a_rsp_valid), 32'(1));
      check("a_rsp_data_n2",  32'(bus.a_rsp_data),  32'(22'h0ABCDE));
      tick();
      check("a_rsp_single", 32'(bus.a_rsp_valid), 32'(0));
      repeat (2) tick();
      check("a_alone_a_cnt", 32'(a_seen - a0), 32'(1));
      check("a_alone_b_cnt", 32'(b_seen - b0), 32'(0));

      // Contention: both read for 4 cycles, grants alternate A,B,A,B
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      a0 = a_seen;
      b0 = b_seen;
      set_a(1'b1, 1'b0, 6'd1, '0);
      set_b(1'b1, 1'b0, 6'd2, '0);
      repeat (4) tick();
      set_a(1'b0, 1'b0, '0, '0);
      set_b(1'b0, 1'b0, '0, '0);
      check("cont_cnt", 32'(bus.conflict_cnt), 32'(4));
      repeat (4) tick();
      check("cont_a_rsp", 32'(a_seen - a0), 32'(2));
      check("cont_b_rsp", 32'(b_seen - b0), 32'(2));

      // Lone B: fill addresses 0..9, then 10 back-to-back reads
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_b(1'b1, 1'b1, ADDR_WIDTH'(i), BITS'((i + 1) * 22'h012345));
         tick();
      end
      b0 = b_seen;
      for (int i = 0; i < 10; i++) begin
         set_b(1'b1, 1'b0, ADDR_WIDTH'(i), '0);
         tick();
      end
      set_b(1'b0, 1'b0, '0, '0);
      repeat (4) tick();
      check("b2b_b_rsp", 32'(b_seen - b0), 32'(10));

      // Reset mid-flight: an accepted A read is killed, pointer returns to A
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      set_a(1'b1, 1'b0, 6'd3, '0);
      tick();
      rst_n = 1'b0;
      set_a(1'b0, 1'b0, '0, '0);
      tick();
      rst_n = 1'b1;
      a0 = a_seen;
      set_a(1'b1, 1'b0, 6'd1, '0);
      set_b(1'b1, 1'b0, 6'd2, '0);
      #1;
      check("midrst_a_wins", 32'({bus.a_ready, bus.b_ready}), 32'(2'b10));
      repeat (2) tick();
      set_a(1'b0, 1'b0, '0, '0);
      set_b(1'b0, 1'b0, '0, '0);
      repeat (4) tick();
      check("midrst_a_rsp", 32'(a_seen - a0), 32'(1));

      // Saturation: 20 contended cycles on a 4-bit counter
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      set_a(1'b1, 1'b0, 6'd7, '0);
      set_b(1'b1, 1'b0, 6'd8, '0);
      repeat (20) tick();
      set_a(1'b0, 1'b0, '0, '0);
      set_b(1'b0, 1'b0, '0, '0);
      check("sat_cnt", 32'(bus.conflict_cnt), 32'(15));
      repeat (4) tick();
      check("sat_hold", 32'(bus.conflict_cnt), 32'(15));
      check("sb_drained", 32'(sb.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fakeram_64x22_arbiter.md
Name: fakeram_64x22_arbiter

Overview:
- Shares one single-port fakeram_64x22 macro between two requesters, A and B.
- Each requester gets a valid/ready request channel and a read-response channel.
- Arbitration is round-robin, with one RAM access per cycle.
- All RAM-side signals are registered, and the RAM is never driven with X on we/addr while ce is high, so simulation never corrupts the whole array.

Parameters:
- BITS, 22: data width; must match the RAM.
- WORD_DEPTH, 64: number of RAM words.
- ADDR_WIDTH, 6: address width, equal to log2(WORD_DEPTH).
- CNT_WIDTH, 16: width of the saturating conflict counter.

Ports:
- clk  in  1  single clock; every register updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- a_valid  in  1  requester A has a request.
- a_ready  out  1  A's request is accepted this cycle.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  A's address.
- a_wdata  in  BITS  A's write data.
- a_rsp_valid  out  1  A's read data is valid.
- a_rsp_data  out  BITS  A's read data.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rsp_valid, b_rsp_data: same directions, widths and meanings as the A ports, for requester B.
- ram_ce  out  1  to RAM ce_in.
- ram_we  out  1  to RAM we_in.
- ram_addr  out  ADDR_WIDTH  to RAM addr_in.
- ram_wd  out  BITS  to RAM wd_in.
- ram_rd  in  BITS  from RAM rd_out.
- conflict_cnt  out  CNT_WIDTH  count of cycles in which both requesters were valid.

Behaviour:
- Reset (rst_n=0 at posedge): all of the following clear to 0:
  - ram_ce, ram_we, ram_addr, ram_wd
  - both response-valid pipelines, a_rsp_valid, b_rsp_valid
  - conflict_cnt
  - The priority pointer is set to A.
- Reset mid-operation: a read accepted before reset produces no response. The reset value holds the cycle after rst_n rises.
- Ready generation is combinational from valid and the pointer:
  - a_ready = a_valid & (!b_valid | ptr==A).
  - b_ready = b_valid & (!a_valid | ptr==B).
  - At most one ready is high per cycle. Ready never asserts without valid.
  - Requesters may drop valid without being accepted.
- Pointer update: after any accept, ptr moves to the other requester. With no accept, ptr holds. A lone requester is granted every cycle (back-to-back).
- Accept at edge E0 (the edge ending cycle N):
  - Registered at E0: ram_ce=1, ram_we=we, ram_addr=addr, ram_wd=(we ? wdata : 0).
  - These are driven during cycle N+1 and sampled by the RAM at E1.
  - Read data appears on ram_rd during cycle N+2.
- Idle cycle (no accept): ram_ce=0, ram_we=0, ram_addr=0, ram_wd=0. No X is ever driven.
- Read response:
  - A 2-stage pipeline carries {read, owner} for each accept.
  - x_rsp_valid is high in cycle N+2 for exactly one cycle, only for reads, only for the owning requester.
  - x_rsp_data = ram_rd when x_rsp_valid is high, else 0. Combinational pass-through, not re-registered.
  - Read latency from accept: 2 cycles. Throughput: 1 request per cycle.
- Writes produce no response.
- RAM write semantics (the RAM ORs write data into the stored word) are the RAM's business. The arbiter passes wdata unmodified.
- Read-after-write to the same address, accepted at N then N+1: the read returns post-write data, because the RAM commits the write at E1 before the read samples at E2.
- conflict_cnt increments in every cycle with a_valid & b_valid, and saturates at 2^CNT_WIDTH-1.
- No backpressure on responses: requesters must always sink the rsp channel.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release, hold valids low for 5 cycles -> ram_ce=0, ram_we=0, ram_addr=0, rsp_valid=0 and conflict_cnt=0 throughout.
- A alone: A writes 22'h0ABCDE to addr 5; the next cycle A reads addr 5 -> a_ready high both cycles; ram_ce/ram_we/ram_addr = 1/1/5 then 1/0/5; a_rsp_valid=1 with a_rsp_data=22'h0ABCDE exactly 2 cycles after the read accept; b_rsp_valid stays 0.
- Contention: A and B both hold valid reading addrs 1 and 2 for 4 cycles after reset -> grants go A,B,A,B; ram_addr sequence 1,2,1,2; responses alternate a,b,a,b; conflict_cnt=4.
- Back-to-back lone B: 10 consecutive B reads of addrs 0..9 -> b_ready high all 10 cycles; 10 responses in order, each 2 cycles after its accept; no bubbles.
- Reset mid-flight: accept an A read at addr 3, assert rst_n=0 on the next edge -> a_rsp_valid never pulses; ptr=A, so under subsequent contention A wins first.
- Saturation (CNT_WIDTH=4): both valid for 20 cycles -> conflict_cnt reaches 15 and holds; ram_we is never X while ram_ce=1 (bench assertion).
